// File: rtl/tx_fifo_pkg.sv
// Shared types and helpers for the TX byte FIFO: write-size encoding and
// its conversion to a byte count.
package tx_fifo_pkg;

    typedef enum logic [1:0] {
        FS_BYTE = 2'd0,
        FS_HALF = 2'd1,
        FS_WORD = 2'd2
    } fifo_size_e;

    // The illegal code 3 maps to 8. Writes with that code are rejected before the result is used.
    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/tx_byte_fifo_if.sv
// Bus-side and TX-side handshake bundle for tx_byte_fifo.
// The wmark/above_wmark pair exists only when TX_FIFO_WMARK_EN is defined.
interface tx_byte_fifo_if #(
    parameter int DEPTH    = 64,
    parameter int WR_BYTES = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                    wr_en;
    logic [1:0]              wr_size;
    logic [8*WR_BYTES-1:0]   wr_data;
    logic                    rd_en;
    logic                    clear;
    logic [7:0]              rd_data;
    logic [OCC_W-1:0]        occupancy;
    logic                    full;
    logic                    empty;
    logic                    wr_err;
    logic                    rd_err;
`ifdef TX_FIFO_WMARK_EN
    logic [OCC_W-1:0]        wmark;
    logic                    above_wmark;
`endif

    modport master (
        output wr_en, wr_size, wr_data, rd_en, clear,
`ifdef TX_FIFO_WMARK_EN
        output wmark,
        input  above_wmark,
`endif
        input  rd_data, occupancy, full, empty, wr_err, rd_err
    );

    modport slave (
        input  wr_en, wr_size, wr_data, rd_en, clear,
`ifdef TX_FIFO_WMARK_EN
        input  wmark,
        output above_wmark,
`endif
        output rd_data, occupancy, full, empty, wr_err, rd_err
    );

endinterface

// File: rtl/tx_fifo_mem.sv
// Byte-lane storage for the TX FIFO: WR_BYTES write lanes starting at wr_ptr,
// and one asynchronous read port.
module tx_fifo_mem #(
    parameter  int DEPTH    = 64,
    parameter  int WR_BYTES = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [WR_BYTES-1:0]   lane_en,
    input  logic [AW-1:0]         wr_ptr,
    input  logic [8*WR_BYTES-1:0] wr_data,
    input  logic [AW-1:0]         rd_ptr,
    output logic [7:0]            rd_byte
);

    logic [7:0] mem [DEPTH];

    // Each lane address wraps on its own, so a word can straddle the end of the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_BYTES; i++) begin
            if (lane_en[i]) begin
                mem[wr_ptr + AW'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_byte = mem[rd_ptr];

endmodule

// File: rtl/tx_byte_fifo.sv
// TX byte FIFO: multi-byte writes with all-or-nothing admission, single-byte
// first-word-fall-through reads. The above_wmark output is added when TX_FIFO_WMARK_EN is defined.
module tx_byte_fifo
    import tx_fifo_pkg::*;
#(
    parameter  int DEPTH    = 64,
    parameter  int WR_BYTES = 4,
    localparam int OCC_W    = $clog2(DEPTH) + 1
) (
    input logic            clk,
    input logic            rst,
    tx_byte_fifo_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] MAX_SIZE = 2'($clog2(WR_BYTES));

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    occ_next;
    logic [OCC_W-1:0]    nbytes;
    logic [OCC_W-1:0]    free_bytes;
    logic [WR_BYTES-1:0] lane_en;
    logic [7:0]          mem_byte;
    logic                wr_acc;
    logic                rd_acc;
    logic                empty_i;
    logic                wr_err_q;
    logic                rd_err_q;

    assign empty_i    = (occ == '0);
    assign nbytes     = OCC_W'(size_to_bytes(bus.wr_size));
    assign free_bytes = OCC_W'(DEPTH) - occ;

    // Admission uses only the current occupancy. A pop in the same cycle does not free space for the write.
    always_comb begin
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        occ_next = occ;
        lane_en  = '0;
        if (!bus.clear) begin
            wr_acc = bus.wr_en && (bus.wr_size <= MAX_SIZE) && (nbytes <= free_bytes);
            rd_acc = bus.rd_en && !empty_i;
            if (wr_acc) occ_next = occ_next + nbytes;
            if (rd_acc) occ_next = occ_next - OCC_W'(1);
        end else begin
            occ_next = '0;
        end
        for (int i = 0; i < WR_BYTES; i++) begin
            lane_en[i] = wr_acc && (OCC_W'(i) < nbytes);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(nbytes);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            occ      <= occ_next;
            wr_err_q <= bus.wr_en && !wr_acc;
            rd_err_q <= bus.rd_en && empty_i;
        end
    end

    tx_fifo_mem #(
        .DEPTH    (DEPTH),
        .WR_BYTES (WR_BYTES)
    ) u_mem (
        .clk     (clk),
        .lane_en (lane_en),
        .wr_ptr  (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_ptr  (rd_ptr),
        .rd_byte (mem_byte)
    );

    assign bus.rd_data   = empty_i ? 8'h00 : mem_byte;
    assign bus.occupancy = occ;
    assign bus.full      = (occ == OCC_W'(DEPTH));
    assign bus.empty     = empty_i;
    assign bus.wr_err    = wr_err_q;
    assign bus.rd_err    = rd_err_q;

`ifdef TX_FIFO_WMARK_EN
    logic above_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) above_q <= 1'b0;
        else     above_q <= (occ_next >= bus.wmark);
    end

    assign bus.above_wmark = above_q;
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Scoreboard bench for tx_byte_fifo: a 64-deep instance for the main checks and an
// 8-deep instance for pointer wrap. Watermark checks are included when TX_FIFO_WMARK_EN is defined.
module tb_tx_byte_fifo;
    import tx_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_byte_fifo_if #(.DEPTH(64), .WR_BYTES(4)) bus64 ();
    tx_byte_fifo_if #(.DEPTH(8),  .WR_BYTES(4)) bus8  ();

    tx_byte_fifo #(.DEPTH(64), .WR_BYTES(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
    tx_byte_fifo #(.DEPTH(8),  .WR_BYTES(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q64[$];
    logic [7:0] q8[$];
    int occ_m [2];
    bit exp_wr_err [2];
    bit exp_rd_err [2];
    int wmark_m [2];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_occ(input int sel);
        return sel != 0 ? int'(bus8.occupancy) : int'(bus64.occupancy);
    endfunction

    // Monitors compare each popped byte against the scoreboard while the read is in progress.
    always @(negedge clk) begin
        if (!rst && bus64.rd_en && !bus64.clear && !bus64.empty) begin
            if (q64.size() == 0) check("pop64_unexpected", 1, 0);
            else check("pop64_data", int'(bus64.rd_data), int'(q64.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus8.rd_en && !bus8.clear && !bus8.empty) begin
            if (q8.size() == 0) check("pop8_unexpected", 1, 0);
            else check("pop8_data", int'(bus8.rd_data), int'(q8.pop_front()));
        end
    end

    task automatic applyStimulus(input int sel, input bit wr, input logic [1:0] size,
                                 input logic [31:0] data, input bit rd, input bit clr);
        int depth;
        int n;
        bit acc;
        bit pop;
        depth = (sel != 0) ? 8 : 64;
        n   = 1 << size;
        acc = wr && !clr && (size <= 2'd2) && (n <= depth - occ_m[sel]);
        pop = rd && !clr && (occ_m[sel] > 0);
        exp_wr_err[sel] = wr && !clr && !acc;
        exp_rd_err[sel] = rd && !clr && (occ_m[sel] == 0);
        if (sel != 0) begin
            bus8.wr_en = wr; bus8.wr_size = size; bus8.wr_data = data;
            bus8.rd_en = rd; bus8.clear = clr;
        end else begin
            bus64.wr_en = wr; bus64.wr_size = size; bus64.wr_data = data;
            bus64.rd_en = rd; bus64.clear = clr;
        end
        @(posedge clk);
        #1;
        bus64.wr_en = 1'b0; bus64.rd_en = 1'b0; bus64.clear = 1'b0;
        bus8.wr_en  = 1'b0; bus8.rd_en  = 1'b0; bus8.clear  = 1'b0;
        if (clr) begin
            occ_m[sel] = 0;
            if (sel != 0) q8.delete(); else q64.delete();
        end else begin
            if (pop) occ_m[sel]--;
            if (acc) begin
                for (int i = 0; i < n; i++) begin
                    if (sel != 0) q8.push_back(data[8*i +: 8]);
                    else q64.push_back(data[8*i +: 8]);
                end
                occ_m[sel] += n;
            end
        end
    endtask

    task automatic checkOutput(input int sel, input string tag);
        int depth;
        int head;
        depth = (sel != 0) ? 8 : 64;
        if (sel != 0) head = (q8.size()  != 0) ? int'(q8[0])  : 0;
        else          head = (q64.size() != 0) ? int'(q64[0]) : 0;
        check({tag, "_occ"}, get_occ(sel), occ_m[sel]);
        if (sel != 0) begin
            check({tag, "_full"},   int'(bus8.full),   int'(occ_m[1] == depth));
            check({tag, "_empty"},  int'(bus8.empty),  int'(occ_m[1] == 0));
            check({tag, "_wr_err"}, int'(bus8.wr_err), int'(exp_wr_err[1]));
            check({tag, "_rd_err"}, int'(bus8.rd_err), int'(exp_rd_err[1]));
            check({tag, "_head"},   int'(bus8.rd_data), head);
`ifdef TX_FIFO_WMARK_EN
            check({tag, "_wmark"},  int'(bus8.above_wmark), int'(occ_m[1] >= wmark_m[1]));
`endif
        end else begin
            check({tag, "_full"},   int'(bus64.full),   int'(occ_m[0] == depth));
            check({tag, "_empty"},  int'(bus64.empty),  int'(occ_m[0] == 0));
            check({tag, "_wr_err"}, int'(bus64.wr_err), int'(exp_wr_err[0]));
            check({tag, "_rd_err"}, int'(bus64.rd_err), int'(exp_rd_err[0]));
            check({tag, "_head"},   int'(bus64.rd_data), head);
`ifdef TX_FIFO_WMARK_EN
            check({tag, "_wmark"},  int'(bus64.above_wmark), int'(occ_m[0] >= wmark_m[0]));
`endif
        end
    endtask

    task automatic idle(input int sel);
        applyStimulus(sel, 1'b0, FS_BYTE, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int sel);
        int n;
        n = occ_m[sel];
        for (int i = 0; i < n; i++) applyStimulus(sel, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus64.wr_en = 1'b0; bus64.wr_size = FS_BYTE; bus64.wr_data = '0; bus64.rd_en = 1'b0; bus64.clear = 1'b0;
        bus8.wr_en  = 1'b0; bus8.wr_size  = FS_BYTE; bus8.wr_data  = '0; bus8.rd_en  = 1'b0; bus8.clear  = 1'b0;
        wmark_m[0] = 16;
        wmark_m[1] = 4;
`ifdef TX_FIFO_WMARK_EN
        bus64.wmark = 7'd16;
        bus8.wmark  = 4'd4;
`endif
        occ_m[0] = 0; occ_m[1] = 0;
        exp_wr_err[0] = 0; exp_wr_err[1] = 0; exp_rd_err[0] = 0; exp_rd_err[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput(0, "reset64");
        checkOutput(1, "reset8");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word written, then read back one byte at a time.
        applyStimulus(0, 1'b1, FS_WORD, 32'hDDCCBBAA, 1'b0, 1'b0);
        check("word_occ", get_occ(0), 4);
        check("word_head", int'(bus64.rd_data), 8'hAA);
        drain(0);
        checkOutput(0, "word_drained");
        check("drained_rd_data", int'(bus64.rd_data), 0);

        // Fill to capacity, then overflow by one byte.
        for (int i = 0; i < 15; i++)
            applyStimulus(0, 1'b1, FS_WORD, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0, 1'b0);
        check("fill60_occ", get_occ(0), 60);
        applyStimulus(0, 1'b1, FS_WORD, 32'hF3F2F1F0, 1'b0, 1'b0);
        check("fill64_full", int'(bus64.full), 1);
        applyStimulus(0, 1'b1, FS_BYTE, 32'h000000EE, 1'b0, 1'b0);
        check("ovf_wr_err", int'(bus64.wr_err), 1);
        check("ovf_occ", get_occ(0), 64);
        checkOutput(0, "ovf");
        idle(0);
        checkOutput(0, "ovf_clear");

        // A word that does not fit is rejected outright. A half-word that fits is accepted.
        applyStimulus(0, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
        check("occ62", get_occ(0), 62);
        applyStimulus(0, 1'b1, FS_WORD, 32'h99887766, 1'b0, 1'b0);
        check("occ62_word_rej", int'(bus64.wr_err), 1);
        checkOutput(0, "occ62_word");
        applyStimulus(0, 1'b1, FS_HALF, 32'h0000A5B6, 1'b0, 1'b0);
        check("occ62_half_occ", get_occ(0), 64);
        checkOutput(0, "occ62_half");
        drain(0);
        checkOutput(0, "drain64");

        // Write and pop in the same cycle, then pop on empty.
        applyStimulus(0, 1'b1, FS_WORD, 32'h13121110, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, FS_WORD, 32'h17161514, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, FS_HALF, 32'h00001918, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, FS_HALF, 32'h00001B1A, 1'b1, 1'b0);
        check("simul_occ", get_occ(0), 11);
        checkOutput(0, "simul");
        drain(0);
        applyStimulus(0, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
        check("underflow_rd_err", int'(bus64.rd_err), 1);
        applyStimulus(0, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
        checkOutput(0, "underflow_b2b");
        idle(0);
        checkOutput(0, "underflow_clear");
        applyStimulus(0, 1'b1, FS_BYTE, 32'h0000005C, 1'b0, 1'b0);
        check("post_uf_head", int'(bus64.rd_data), 8'h5C);
        drain(0);
        applyStimulus(0, 1'b1, FS_BYTE, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
        checkOutput(0, "illegal_size");
        drain(0);

        // Clear with a concurrent write and pop discards both and raises no error.
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1'b1, FS_WORD, 32'h40414243 + 32'(i), 1'b0, 1'b0);
        check("pre_clear_occ", get_occ(0), 20);
        applyStimulus(0, 1'b1, FS_WORD, 32'hDEADBEEF, 1'b1, 1'b1);
        check("clear_occ", get_occ(0), 0);
        check("clear_empty", int'(bus64.empty), 1);
        checkOutput(0, "clear");

        // Refill after the clear. These writes also cross the watermark of 16.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, FS_WORD, 32'hC3C2C1C0 + 32'(i << 4), 1'b0, 1'b0);
            checkOutput(0, "wmark_fill");
        end
`ifdef TX_FIFO_WMARK_EN
        check("wmark_at16", int'(bus64.above_wmark), 1);
`endif
        drain(0);
        checkOutput(0, "final64");

        // On the 8-deep instance, a word write crosses index 7 to 0.
        applyStimulus(1, 1'b1, FS_WORD, 32'h0D0C0B0A, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, FS_HALF, 32'h00000F0E, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1'b0, FS_BYTE, 32'h0, 1'b1, 1'b0);
        check("wrap_pre_head", int'(bus8.rd_data), 8'h0F);
        applyStimulus(1, 1'b1, FS_WORD, 32'h44332211, 1'b0, 1'b0);
        check("wrap_occ", get_occ(1), 5);
        checkOutput(1, "wrap");
        drain(1);
        checkOutput(1, "wrap_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
